// File: rtl/seq_detect_sched.sv
// Shared, runtime-programmable serial pattern detector for NCH bit-serial channels.
// A round-robin arbiter feeds one channel per cycle into a single match engine backed by per-channel context.
module seq_detect_sched #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned PAT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH-1:0]           in_bit,
    output logic [NCH-1:0]           in_ready,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [2:0]               cfg_len,
    input  logic                     cfg_overlap,
    output logic                     match_valid,
    output logic [$clog2(NCH)-1:0]   match_ch,
    output logic [15:0]              match_total
);

    localparam int unsigned CHW = $clog2(NCH);

    logic [CHW-1:0]   ptr_q;
    logic [PAT_W-1:0] hist_q [NCH];
    logic [3:0]       fill_q [NCH];
    logic [PAT_W-1:0] pat_q;
    logic [2:0]       len_q;
    logic             ovl_q;

    logic [NCH-1:0]   grant;
    logic [CHW-1:0]   gnt_idx;
    logic [CHW-1:0]   cand;
    logic             found;

    logic [3:0]       len_ext;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] h_cur;
    logic [PAT_W-1:0] h_new;
    logic [3:0]       f_cur;
    logic [3:0]       f_new;
    logic             hit;

    // Round-robin: first requester at or after ptr_q, wrapping modulo NCH.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cand = CHW'((int'(ptr_q) + i) % NCH);
            if (!found && in_valid[cand]) begin
                found         = 1'b1;
                grant[cand]   = 1'b1;
                gnt_idx       = cand;
            end
        end
        if (cfg_we || !rst_n) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign in_ready = grant;

    always_comb begin
        len_ext = {1'b0, len_q} + 4'd1;
        mask    = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_ext));
        end
        h_cur = hist_q[gnt_idx];
        f_cur = fill_q[gnt_idx];
        h_new = {h_cur[PAT_W-2:0], in_bit[gnt_idx]};
        f_new = (f_cur >= len_ext) ? len_ext : f_cur + 4'd1;
        hit   = found && (f_new == len_ext) && (((h_new ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            pat_q       <= PAT_W'(8'b0000_1010);
            len_q       <= 3'd3;
            ovl_q       <= 1'b0;
            match_valid <= 1'b0;
            match_ch    <= '0;
            match_total <= '0;
            for (int c = 0; c < NCH; c++) begin
                hist_q[c] <= '0;
                fill_q[c] <= '0;
            end
        end else if (cfg_we) begin
            pat_q       <= cfg_pattern;
            len_q       <= cfg_len;
            ovl_q       <= cfg_overlap;
            match_valid <= 1'b0;
            match_total <= '0;
            for (int c = 0; c < NCH; c++) begin
                hist_q[c] <= '0;
                fill_q[c] <= '0;
            end
        end else begin
            match_valid <= hit;
            if (hit) begin
                match_ch <= gnt_idx;
                if (match_total != 16'hFFFF) begin
                    match_total <= match_total + 16'd1;
                end
            end
            if (found) begin
                ptr_q            <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
                hist_q[gnt_idx]  <= h_new;
                // Non-overlapping mode restarts progress after a hit; history still shifts.
                fill_q[gnt_idx]  <= (hit && !ovl_q) ? 4'd0 : f_new;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed self-checking bench for seq_detect_sched: default/overlap detection, round-robin
// interleave, config blocking, single-bit patterns and mid-stream reset.
module tb_seq_detect_sched;

    localparam int unsigned NCH   = 4;
    localparam int unsigned PAT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_bit;
    logic [NCH-1:0]   in_ready;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [2:0]       cfg_len;
    logic             cfg_overlap;
    logic             match_valid;
    logic [1:0]       match_ch;
    logic [15:0]      match_total;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_sched #(.NCH(NCH), .PAT_W(PAT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_total (match_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit on a single channel; checks ready before the edge and the match pulse after it.
    task automatic send(input int ch, input logic b, input logic exp_mv, input string tag);
        in_valid = 4'(1 << ch);
        in_bit   = b ? 4'(1 << ch) : 4'b0000;
        #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'(1 << ch));
        tick();
        chk({tag, "_mv"}, 32'(match_valid), 32'(exp_mv));
        if (exp_mv) chk({tag, "_ch"}, 32'(match_ch), 32'(ch));
        in_valid = '0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [2:0] len, input logic ovl);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
        chk("cfg_total_clr", 32'(match_total), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = '0;
        in_bit      = '0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_mv", 32'(match_valid), 32'd0);
        chk("rst_ch", 32'(match_ch), 32'd0);
        chk("rst_total", 32'(match_total), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);

        // Default non-overlapping 1010 on ch0
        send(0, 1'b1, 1'b0, "d1"); send(0, 1'b0, 1'b0, "d2");
        send(0, 1'b1, 1'b0, "d3"); send(0, 1'b0, 1'b1, "d4");
        send(0, 1'b1, 1'b0, "d5"); send(0, 1'b0, 1'b0, "d6");
        send(0, 1'b1, 1'b0, "d7"); send(0, 1'b0, 1'b1, "d8");
        tick();
        chk("def_total", 32'(match_total), 32'd2);
        chk("def_mv_once", 32'(match_valid), 32'd0);

        // Overlapping 1010
        load_cfg(8'h0A, 3'd3, 1'b1);
        send(0, 1'b1, 1'b0, "o1"); send(0, 1'b0, 1'b0, "o2");
        send(0, 1'b1, 1'b0, "o3"); send(0, 1'b0, 1'b1, "o4");
        send(0, 1'b1, 1'b0, "o5"); send(0, 1'b0, 1'b1, "o6");
        send(0, 1'b1, 1'b0, "o7"); send(0, 1'b0, 1'b1, "o8");
        tick();
        chk("ovl_total", 32'(match_total), 32'd3);

        // Reset back to defaults and ptr=0, then interleave all four channels
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_total", 32'(match_total), 32'd0);
        in_valid = 4'hF;
        for (int t = 0; t < 16; t++) begin
            in_bit = (((t / 4) % 2) == 0) ? 4'hF : 4'h0;
            #1;
            chk("rr_rdy", 32'(in_ready), 32'(1 << (t % 4)));
            tick();
            chk("rr_mv", 32'(match_valid), 32'(t >= 12));
            if (t >= 12) chk("rr_ch", 32'(match_ch), 32'(t - 12));
        end
        in_valid = '0;
        tick();
        chk("rr_total", 32'(match_total), 32'd4);

        // Config write while ch1 holds a bit: nothing is consumed
        send(1, 1'b1, 1'b0, "c1"); send(1, 1'b0, 1'b0, "c2"); send(1, 1'b1, 1'b0, "c3");
        in_valid    = 4'b0010;
        in_bit      = 4'b0000;
        cfg_pattern = 8'h0A;
        cfg_len     = 3'd3;
        cfg_overlap = 1'b0;
        cfg_we      = 1'b1;
        #1;
        chk("cfg_block_rdy", 32'(in_ready), 32'd0);
        tick();
        cfg_we = 1'b0;
        chk("cfg_block_mv", 32'(match_valid), 32'd0);
        send(1, 1'b0, 1'b0, "c4");
        send(1, 1'b1, 1'b0, "c5"); send(1, 1'b0, 1'b0, "c6");
        send(1, 1'b1, 1'b0, "c7"); send(1, 1'b0, 1'b1, "c8");
        tick();
        chk("cfg_total", 32'(match_total), 32'd1);

        // Single-bit pattern; upper pattern bits must be ignored
        load_cfg(8'hF1, 3'd0, 1'b0);
        send(0, 1'b1, 1'b1, "s1"); send(0, 1'b1, 1'b1, "s2");
        send(0, 1'b0, 1'b0, "s3"); send(0, 1'b1, 1'b1, "s4");
        tick();
        chk("single_total", 32'(match_total), 32'd3);

        // Mid-stream reset on ch2
        load_cfg(8'h0A, 3'd3, 1'b0);
        send(2, 1'b1, 1'b0, "r1"); send(2, 1'b0, 1'b0, "r2");
        send(2, 1'b1, 1'b0, "r3"); send(2, 1'b0, 1'b1, "r4");
        send(2, 1'b1, 1'b0, "r5"); send(2, 1'b0, 1'b0, "r6");
        send(2, 1'b1, 1'b0, "r7");
        rst_n    = 1'b0;
        in_valid = 4'b0100;
        in_bit   = 4'b0000;
        #1;
        chk("inrst_rdy", 32'(in_ready), 32'd0);
        tick();
        rst_n    = 1'b1;
        in_valid = '0;
        chk("postrst_mv", 32'(match_valid), 32'd0);
        chk("postrst_ch", 32'(match_ch), 32'd0);
        chk("postrst_total", 32'(match_total), 32'd0);
        send(2, 1'b0, 1'b0, "r8");
        tick();
        chk("rst_final_total", 32'(match_total), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
